// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the core's instruction-fetch port
// (read-only) and its data port (read/write). Each memory access is a
// three-cycle transaction IDLE -> ACCESS -> DONE. Data requests beat fetch
// requests, but a run counter caps how many data grants in a row may pass
// a waiting fetch. Word addresses at or above ADDR_LIMIT never reach the
// memory; they complete with an error flag and zero read data.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   f_req/f_addr          fetch request (level) and word address
//   f_ack/f_rdata/f_err   fetch completion pulse, read data, range error
//   d_req/d_rw/d_addr     data request (level), 1=write, word address
//   d_wdata               data write data
//   d_ack/d_rdata/d_err   data completion pulse, read data, range error
//   mem_enable/mem_rw     memory strobe and direction
//   mem_addr/mem_wdata    memory address and write data
//   mem_drive             tristate enable for mem_wdata onto the data bus
//   mem_rdata             memory data bus, sampled at the end of ACCESS
//   busy                  high whenever the FSM is not in IDLE
//   grant_d               1 = current/last transaction belongs to data port
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned ADDR_LIMIT   = 32'd4096,
   parameter int unsigned MAX_DATA_RUN = 32'd4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        f_req,
   input  logic [23:0] f_addr,
   output logic        f_ack,
   output logic [31:0] f_rdata,
   output logic        f_err,
   input  logic        d_req,
   input  logic        d_rw,
   input  logic [23:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_enable,
   output logic        mem_rw,
   output logic [23:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_drive,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        grant_d
);

   // Run counter must be able to hold MAX_DATA_RUN itself.
   localparam int RUN_W = (MAX_DATA_RUN < 32'd1) ? 1 : $clog2(MAX_DATA_RUN + 32'd1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
   // One extra bit so a limit of 1<<24 (whole address space legal) still works.
   localparam logic [24:0] LIMIT_W = 25'(ADDR_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            state_q;
   logic [RUN_W-1:0]  run_q;
   logic [23:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              rw_q;
   logic              oor_q;
   logic              grant_d_q;
   logic              mem_enable_q;
   logic              mem_rw_q;
   logic              mem_drive_q;
   logic              busy_q;
   logic              f_ack_q;
   logic              f_err_q;
   logic [31:0]       f_rdata_q;
   logic              d_ack_q;
   logic              d_err_q;
   logic [31:0]       d_rdata_q;

   logic              pick_data_d;
   logic              pick_fetch_d;
   logic [RUN_W-1:0]  run_d;
   logic [23:0]       sel_addr_d;
   logic              sel_rw_d;
   logic [31:0]       sel_wdata_d;
   logic              sel_oor_d;
   logic [31:0]       rdata_cap_d;

   // Arbitration decision and winner selection, evaluated every cycle but
   // only acted on while the FSM sits in IDLE.
   always_comb begin
      pick_data_d  = 1'b0;
      pick_fetch_d = 1'b0;
      run_d        = run_q;
      if (d_req && (!f_req || (run_q < RUN_MAX))) begin
         pick_data_d = 1'b1;
         // Only a fetch that is actually waiting makes the data run count.
         if (f_req) begin
            run_d = run_q + RUN_W'(1'b1);
         end else begin
            run_d = '0;
         end
      end else if (f_req) begin
         pick_fetch_d = 1'b1;
         run_d        = '0;
      end else begin
         run_d = run_q;
      end

      if (pick_data_d) begin
         sel_addr_d  = d_addr;
         sel_rw_d    = d_rw;
         sel_wdata_d = d_wdata;
      end else begin
         sel_addr_d  = f_addr;
         sel_rw_d    = 1'b0;
         sel_wdata_d = 32'd0;
      end

      sel_oor_d = ({1'b0, sel_addr_d} >= LIMIT_W);
   end

   // Read result for the transaction closing this cycle; out-of-range reads
   // return zero because the memory was never enabled.
   always_comb begin
      if (oor_q) begin
         rdata_cap_d = 32'd0;
      end else begin
         rdata_cap_d = mem_rdata;
      end
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         run_q        <= '0;
         addr_q       <= 24'd0;
         wdata_q      <= 32'd0;
         rw_q         <= 1'b0;
         oor_q        <= 1'b0;
         grant_d_q    <= 1'b0;
         mem_enable_q <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_drive_q  <= 1'b0;
         busy_q       <= 1'b0;
         f_ack_q      <= 1'b0;
         f_err_q      <= 1'b0;
         f_rdata_q    <= 32'd0;
         d_ack_q      <= 1'b0;
         d_err_q      <= 1'b0;
         d_rdata_q    <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               run_q <= run_d;
               if (pick_data_d || pick_fetch_d) begin
                  state_q      <= S_ACCESS;
                  grant_d_q    <= pick_data_d;
                  addr_q       <= sel_addr_d;
                  rw_q         <= sel_rw_d;
                  wdata_q      <= sel_wdata_d;
                  oor_q        <= sel_oor_d;
                  mem_enable_q <= !sel_oor_d;
                  mem_rw_q     <= !sel_oor_d && sel_rw_d;
                  mem_drive_q  <= !sel_oor_d && sel_rw_d;
                  busy_q       <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end

            S_ACCESS: begin
               state_q      <= S_DONE;
               mem_enable_q <= 1'b0;
               mem_rw_q     <= 1'b0;
               mem_drive_q  <= 1'b0;
               // Only the winner's completion registers move.
               if (grant_d_q) begin
                  d_ack_q <= 1'b1;
                  d_err_q <= oor_q;
                  if (!rw_q) begin
                     d_rdata_q <= rdata_cap_d;
                  end
               end else begin
                  f_ack_q <= 1'b1;
                  f_err_q <= oor_q;
                  if (!rw_q) begin
                     f_rdata_q <= rdata_cap_d;
                  end
               end
            end

            S_DONE: begin
               // Requests are ignored here; a held request is re-arbitrated
               // from IDLE as a new one.
               state_q <= S_IDLE;
               f_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q      <= S_IDLE;
               mem_enable_q <= 1'b0;
               mem_rw_q     <= 1'b0;
               mem_drive_q  <= 1'b0;
               f_ack_q      <= 1'b0;
               d_ack_q      <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign f_ack      = f_ack_q;
   assign f_rdata    = f_rdata_q;
   assign f_err      = f_err_q;
   assign d_ack      = d_ack_q;
   assign d_rdata    = d_rdata_q;
   assign d_err      = d_err_q;
   assign mem_enable = mem_enable_q;
   assign mem_rw     = mem_rw_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_drive  = mem_drive_q;
   assign busy       = busy_q;
   assign grant_d    = grant_d_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port Mem between the Core's instruction-fetch port (read-only) and data port (read/write). The block sits between Core and Mem in Top, sequences every Mem access as a three-cycle transaction, and applies data-over-fetch priority with a starvation guard. Accesses at or above ADDR_LIMIT are answered with an error and never reach Mem.

Parameters:
ADDR_LIMIT, 1 << 12, first illegal word address; must match the Mem instance SIZE+BASE
MAX_DATA_RUN, 4, consecutive data grants allowed while fetch waits (minimum 1)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous active-low reset
f_req  input  1  fetch request, level, held until f_ack is seen
f_addr  input  24  fetch word address
f_ack  output  1  one-cycle completion pulse for fetch
f_rdata  output  32  fetch read data, valid while f_ack=1 and held until the next fetch ack
f_err  output  1  valid with f_ack; 1 = address out of range
d_req  input  1  data request, level, held until d_ack is seen
d_rw  input  1  1 = write, 0 = read
d_addr  input  24  data word address
d_wdata  input  32  write data
d_ack  output  1  one-cycle completion pulse for data
d_rdata  output  32  data read data, valid while d_ack=1 and held until the next data ack
d_err  output  1  valid with d_ack; 1 = address out of range
mem_enable  output  1  to Mem enable
mem_rw  output  1  to Mem rw
mem_addr  output  24  to Mem address
mem_wdata  output  32  write data; Top drives the shared bus with it while mem_drive=1
mem_drive  output  1  tristate enable for mem_wdata onto the Mem data bus
mem_rdata  input  32  Mem data bus, sampled
busy  output  1  high in any state except IDLE
grant_d  output  1  1 = current or last transaction belongs to the data port

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; run counter 0; rdata registers 0. Any transaction in flight is abandoned with no ack. Release is synchronous to the next rising edge.
- States: IDLE -> ACCESS -> DONE -> IDLE. The block completes at most one transaction per 3 cycles.
- IDLE, arbitration at each rising edge:
  - No request: stay in IDLE.
  - d_req=1 and (f_req=0 or run<MAX_DATA_RUN): grant data. run increments if f_req=1; otherwise run clears to 0.
  - Otherwise, if f_req=1: grant fetch and clear run to 0.
  - On grant: register the winner's addr, rw and wdata (fetch rw=0), and set grant_d.
- Range check at grant:
  - addr >= ADDR_LIMIT (unsigned 24-bit compare): go to ACCESS with mem_enable=0.
  - Legal address: go to ACCESS with mem_enable=1 and mem_rw=rw; mem_drive=rw.
- ACCESS (one cycle): outputs are held stable. Mem samples on the mid-cycle falling edge. At the closing rising edge:
  - The read result is captured from mem_rdata (0 if out of range) into the winner's rdata register.
  - err is set for the winner; mem_enable, mem_rw and mem_drive go to 0; state goes to DONE.
  - For writes, the winner's rdata register is left unchanged.
- DONE (one cycle): the winner's ack=1 and all requests are ignored. The next edge returns to IDLE.
  - A requester that sampled ack may reassert or keep req from IDLE onward; a held req is treated as a new request.
- At most one ack is high at any time. The non-winner's ack, rdata and err are unchanged.
- Simultaneous f_req and d_req after reset: data wins.
- Fetch latency (from the req edge in IDLE to ack high) is 2 cycles when uncontended.
- Back-to-back data requests with fetch pending: fetch is granted no later than after MAX_DATA_RUN data transactions.

Test Plan:
- Reset release, no requests: all outputs 0 and busy=0 for 10 cycles.
- Mem preloaded with ram[5]=0xDEADBEEF; f_req, f_addr=5: mem_enable high for exactly 1 cycle with mem_rw=0; f_ack pulses 2 cycles after the req edge; f_rdata=0xDEADBEEF, f_err=0.
- Data write 0x12345678 to addr 7, then data read of addr 7: write shows mem_drive=1 and mem_rw=1 in ACCESS; read returns d_rdata=0x12345678, and f_rdata is unchanged.
- d_req and f_req held continuously with MAX_DATA_RUN=4: grant sequence is D,D,D,D,F,D,D,D,D,F; never two acks at once.
- d_addr=0x001000 (=ADDR_LIMIT), read: mem_enable stays 0; d_ack with d_err=1 and d_rdata=0; the next legal access has d_err=0.
- reset_n pulsed low during ACCESS of a data write: outputs go to 0 immediately with no d_ack; after release a held d_req is re-arbitrated from IDLE and the write completes.
